// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: RV32I memory-stage load/store unit.
//
// Sits between the EX/MEM pipeline register and the data-memory port. It
// accepts one load or store from EX while idle. It then runs a req/gnt/rvalid
// access to memory and sign/zero-extends load data into a registered
// writeback result.
//
// Ports
//   clk, rst_n          : core clock, asynchronous active-low reset
//   ex_valid_i          : EX/MEM register holds a valid instruction
//   ls_func_i           : NOP=0 LW=1 LH=2 LB=3 LHU=4 LBU=5 SW=6 SH=7 SB=8 (9-15 = NOP)
//   addr_i, wdata_i     : effective byte address, forwarded store data
//   rd_i                : load destination register
//   data_req_o/gnt_i    : memory request / request accepted
//   data_we_o, data_be_o: store flag, byte enables
//   data_addr_o         : word-aligned address
//   data_wdata_o        : lane-replicated store data
//   data_rvalid_i/rdata_i : read data return
//   lsu_busy_o          : upstream stall, high whenever not idle
//   wb_valid_o, wb_rd_o, wb_data_o : one-cycle load result toward WB
//   misaligned_o        : one-cycle pulse, misaligned access rejected
//   bus_err_o           : one-cycle pulse, access aborted on timeout
//
// Memory handshake: data_req_o is high for every REQ cycle. Address, be, we
// and wdata are held stable until the cycle where data_gnt_i is also high;
// that cycle is the transfer. data_rvalid_i is only looked at in WAIT_RVALID,
// so an rvalid that lands in the gnt cycle is ignored.

module lsu_mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid_i,
  input  logic [3:0]  ls_func_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  rd_i,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  output logic        lsu_busy_o,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        misaligned_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  localparam logic [3:0] F_LW  = 4'd1;
  localparam logic [3:0] F_LH  = 4'd2;
  localparam logic [3:0] F_LB  = 4'd3;
  localparam logic [3:0] F_LHU = 4'd4;
  localparam logic [3:0] F_LBU = 4'd5;
  localparam logic [3:0] F_SW  = 4'd6;
  localparam logic [3:0] F_SH  = 4'd7;
  localparam logic [3:0] F_SB  = 4'd8;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [1:0]       off_q, off_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             we_q, we_d;
  logic [3:0]       func_q, func_d;
  logic [4:0]       rd_q, rd_d;
  logic             wb_valid_q, wb_valid_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic             mis_q, mis_d;
  logic             err_q, err_d;

  // Request decode from EX.
  logic        is_word, is_half, is_byte, is_store, accept, misaligned;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic        timeout;
  logic [31:0] rdata_sh;
  logic [31:0] load_ext;

  always_comb begin
    is_word  = (ls_func_i == F_LW) || (ls_func_i == F_SW);
    is_half  = (ls_func_i == F_LH) || (ls_func_i == F_LHU) || (ls_func_i == F_SH);
    is_byte  = (ls_func_i == F_LB) || (ls_func_i == F_LBU) || (ls_func_i == F_SB);
    is_store = (ls_func_i == F_SW) || (ls_func_i == F_SH) || (ls_func_i == F_SB);
    // Codes 0 and 9-15 fall into none of the size classes, so they are NOPs.
    accept   = ex_valid_i && (is_word || is_half || is_byte);
    misaligned = (is_word && (addr_i[1:0] != 2'b00)) || (is_half && addr_i[0]);

    be_calc    = 4'b1111;
    wdata_calc = wdata_i;
    if (is_half) begin
      be_calc    = 4'b0011 << addr_i[1:0];
      wdata_calc = {2{wdata_i[15:0]}};
    end else if (is_byte) begin
      be_calc    = 4'b0001 << addr_i[1:0];
      wdata_calc = {4{wdata_i[7:0]}};
    end
  end

  assign timeout = (cnt_q == CNT_LAST);

  // Load alignment and extension, using the byte offset captured at accept.
  always_comb begin
    rdata_sh = data_rdata_i >> {off_q, 3'b000};
    case (func_q)
      F_LB:    load_ext = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      F_LBU:   load_ext = {24'h000000, rdata_sh[7:0]};
      F_LH:    load_ext = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      F_LHU:   load_ext = {16'h0000, rdata_sh[15:0]};
      default: load_ext = rdata_sh;
    endcase
  end

  // FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept && !misaligned) state_d = S_REQ;
      S_REQ: begin
        if (data_gnt_i)   state_d = we_q ? S_IDLE : S_WAIT;
        else if (timeout) state_d = S_IDLE;
      end
      S_WAIT: if (data_rvalid_i || timeout) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs decoded from state.
  always_comb begin
    data_req_o = (state_q == S_REQ);
    lsu_busy_o = (state_q != S_IDLE);
  end

  // Datapath next values: captured access fields, timeout counter and the
  // registered one-cycle pulses (which default back to 0 every cycle).
  always_comb begin
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    off_d      = off_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    func_d     = func_q;
    rd_d       = rd_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    mis_d      = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (misaligned) begin
            mis_d = 1'b1;
          end else begin
            addr_d  = {addr_i[31:2], 2'b00};
            off_d   = addr_i[1:0];
            be_d    = be_calc;
            wdata_d = wdata_calc;
            we_d    = is_store;
            func_d  = ls_func_i;
            rd_d    = rd_i;
            cnt_d   = '0;
          end
        end
      end
      S_REQ: begin
        if (data_gnt_i) begin
          cnt_d = '0;
        end else if (timeout) begin
          err_d = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WAIT: begin
        if (data_rvalid_i) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = load_ext;
          cnt_d      = '0;
        end else if (timeout) begin
          err_d = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      addr_q     <= '0;
      off_q      <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      func_q     <= '0;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      mis_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      off_q      <= off_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      func_q     <= func_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      mis_q      <= mis_d;
      err_q      <= err_d;
    end
  end

  assign data_we_o    = we_q;
  assign data_be_o    = be_q;
  assign data_addr_o  = addr_q;
  assign data_wdata_o = wdata_q;
  assign wb_valid_o   = wb_valid_q;
  assign wb_rd_o      = wb_rd_q;
  assign wb_data_o    = wb_data_q;
  assign misaligned_o = mis_q;
  assign bus_err_o    = err_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Testbench for lsu_mem_stage: directed loads/stores with hand-computed
// expected events queued in a scoreboard and checked by a negedge monitor.

module tb_lsu_mem_stage;

  localparam int W = 72;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid_i;
  logic [3:0]  ls_func_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [4:0]  rd_i;
  logic        data_req_o;
  logic        data_gnt_i;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;
  logic        lsu_busy_o;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        misaligned_o;
  logic        bus_err_o;

  lsu_mem_stage #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid_i    (ex_valid_i),
    .ls_func_i     (ls_func_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .rd_i          (rd_i),
    .data_req_o    (data_req_o),
    .data_gnt_i    (data_gnt_i),
    .data_we_o     (data_we_o),
    .data_be_o     (data_be_o),
    .data_addr_o   (data_addr_o),
    .data_wdata_o  (data_wdata_o),
    .data_rvalid_i (data_rvalid_i),
    .data_rdata_i  (data_rdata_i),
    .lsu_busy_o    (lsu_busy_o),
    .wb_valid_o    (wb_valid_o),
    .wb_rd_o       (wb_rd_o),
    .wb_data_o     (wb_data_o),
    .misaligned_o  (misaligned_o),
    .bus_err_o     (bus_err_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // Event encoding: {kind[2:0], a[31:0], be[3:0], we, d[31:0]}
  //   1 store transfer, 2 load transfer (d=0), 3 writeback (a=rd),
  //   4 misaligned pulse, 5 bus error pulse.
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int req_cycles  = 0;
  int busy_cycles = 0;

  function automatic logic [W-1:0] mk(input logic [2:0] kind, input logic [31:0] a,
                                      input logic [3:0] be, input logic we,
                                      input logic [31:0] d);
    return {kind, a, be, we, d};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic observe(input string name, input logic [W-1:0] ev);
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_%s: got %h expected no event", name, ev);
    end else begin
      check(name, ev, exp_q.pop_front());
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_req_o) req_cycles++;
      if (lsu_busy_o) busy_cycles++;
      if (data_req_o && data_gnt_i)
        observe("mem_xfer", mk(data_we_o ? 3'd1 : 3'd2, data_addr_o, data_be_o, data_we_o,
                               data_we_o ? data_wdata_o : 32'h0));
      if (wb_valid_o)   observe("wb", mk(3'd3, {27'h0, wb_rd_o}, 4'h0, 1'b0, wb_data_o));
      if (misaligned_o) observe("misaligned", mk(3'd4, 32'h0, 4'h0, 1'b0, 32'h0));
      if (bus_err_o)    observe("bus_err", mk(3'd5, 32'h0, 4'h0, 1'b0, 32'h0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [3:0] func, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd);
    @(posedge clk); #1;
    ex_valid_i = 1'b1; ls_func_i = func; addr_i = addr; wdata_i = wdata; rd_i = rd;
    @(posedge clk); #1;
    ex_valid_i = 1'b0; ls_func_i = 4'd0;
  endtask

  // Load with gnt in the first REQ cycle; rvalid arrives 'gap' cycles after
  // the first WAIT_RVALID cycle.
  task automatic do_load(input logic [3:0] func, input logic [31:0] addr,
                         input logic [4:0] rd, input logic [31:0] rdata, input int gap);
    issue(func, addr, 32'h0, rd);
    @(posedge clk); #1;
    repeat (gap) begin @(posedge clk); #1; end
    data_rvalid_i = 1'b1; data_rdata_i = rdata;
    @(posedge clk); #1;
    data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // ---------------- stimulus ----------------
  int r0, b0;

  initial begin
    rst_n = 1'b0; ex_valid_i = 1'b0; ls_func_i = 4'd0; addr_i = 32'h0; wdata_i = 32'h0;
    rd_i = 5'd0; data_gnt_i = 1'b1; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
    repeat (2) @(posedge clk); #1;
    check("reset_mem_port", W'({data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o}), '0);
    check("reset_wb_port", W'({wb_valid_o, wb_rd_o, wb_data_o, misaligned_o, bus_err_o, lsu_busy_o}), '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // SW word store, gnt on first REQ cycle.
    r0 = req_cycles; b0 = busy_cycles;
    exp_q.push_back(mk(3'd1, 32'h0000_1004, 4'hF, 1'b1, 32'hDEAD_BEEF));
    issue(4'd6, 32'h0000_1004, 32'hDEAD_BEEF, 5'd0);
    repeat (3) begin @(posedge clk); #1; end
    check("sw_req_cycles", W'(req_cycles - r0), W'(1));
    check("sw_busy_cycles", W'(busy_cycles - b0), W'(1));

    // SB to the top byte lane.
    exp_q.push_back(mk(3'd1, 32'h0000_2000, 4'b1000, 1'b1, 32'hA5A5_A5A5));
    issue(4'd8, 32'h0000_2003, 32'h0000_00A5, 5'd0);
    repeat (3) begin @(posedge clk); #1; end

    // SH to the upper half.
    exp_q.push_back(mk(3'd1, 32'h0000_8000, 4'b1100, 1'b1, 32'hABCD_ABCD));
    issue(4'd7, 32'h0000_8002, 32'h1234_ABCD, 5'd0);
    repeat (3) begin @(posedge clk); #1; end

    // LB / LBU at byte 2 of 0x0080FF11 (byte = 0x80), rvalid 2 cycles after gnt.
    exp_q.push_back(mk(3'd2, 32'h0000_3000, 4'b0100, 1'b0, 32'h0));
    exp_q.push_back(mk(3'd3, 32'd7, 4'h0, 1'b0, 32'hFFFF_FF80));
    do_load(4'd3, 32'h0000_3002, 5'd7, 32'h0080_FF11, 1);
    exp_q.push_back(mk(3'd2, 32'h0000_3000, 4'b0100, 1'b0, 32'h0));
    exp_q.push_back(mk(3'd3, 32'd8, 4'h0, 1'b0, 32'h0000_0080));
    do_load(4'd5, 32'h0000_3002, 5'd8, 32'h0080_FF11, 1);

    // LW at minimum latency, rd=0 still writes back; busy = REQ + WAIT.
    b0 = busy_cycles;
    exp_q.push_back(mk(3'd2, 32'h0000_7000, 4'hF, 1'b0, 32'h0));
    exp_q.push_back(mk(3'd3, 32'd0, 4'h0, 1'b0, 32'h1234_5678));
    do_load(4'd1, 32'h0000_7000, 5'd0, 32'h1234_5678, 0);
    check("lw_min_busy_cycles", W'(busy_cycles - b0), W'(2));

    // LH upper half with a stray rvalid in the gnt cycle that must be ignored.
    exp_q.push_back(mk(3'd2, 32'h0000_6000, 4'b1100, 1'b0, 32'h0));
    exp_q.push_back(mk(3'd3, 32'd3, 4'h0, 1'b0, 32'hFFFF_8001));
    issue(4'd2, 32'h0000_6002, 32'h0, 5'd3);
    data_rvalid_i = 1'b1; data_rdata_i = 32'h1111_2222;
    @(posedge clk); #1;
    data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
    @(posedge clk); #1;
    data_rvalid_i = 1'b1; data_rdata_i = 32'h8001_3344;
    @(posedge clk); #1;
    data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
    repeat (2) begin @(posedge clk); #1; end

    // Misaligned LH, LW, SW: one pulse each, no request, no busy.
    r0 = req_cycles; b0 = busy_cycles;
    exp_q.push_back(mk(3'd4, 32'h0, 4'h0, 1'b0, 32'h0));
    issue(4'd2, 32'h0000_4001, 32'h0, 5'd1);
    exp_q.push_back(mk(3'd4, 32'h0, 4'h0, 1'b0, 32'h0));
    issue(4'd1, 32'h0000_4002, 32'h0, 5'd1);
    exp_q.push_back(mk(3'd4, 32'h0, 4'h0, 1'b0, 32'h0));
    issue(4'd6, 32'h0000_4001, 32'hFFFF_FFFF, 5'd0);
    // Function code 10 is a NOP: nothing at all.
    issue(4'd10, 32'h0000_4000, 32'h0, 5'd1);
    repeat (3) begin @(posedge clk); #1; end
    check("misaligned_req_cycles", W'(req_cycles - r0), W'(0));
    check("misaligned_busy_cycles", W'(busy_cycles - b0), W'(0));

    // LW with gnt withheld: abort after 64 REQ cycles.
    data_gnt_i = 1'b0;
    r0 = req_cycles; b0 = busy_cycles;
    exp_q.push_back(mk(3'd5, 32'h0, 4'h0, 1'b0, 32'h0));
    issue(4'd1, 32'h0000_9000, 32'h0, 5'd9);
    repeat (70) begin @(posedge clk); #1; end
    check("timeout_req_cycles", W'(req_cycles - r0), W'(64));
    check("timeout_busy_cycles", W'(busy_cycles - b0), W'(64));
    check("timeout_req_low", W'(data_req_o), W'(0));
    data_gnt_i = 1'b1;

    // LHU interrupted by reset in WAIT_RVALID; later rvalid is ignored.
    exp_q.push_back(mk(3'd2, 32'h0000_5000, 4'b1100, 1'b0, 32'h0));
    issue(4'd4, 32'h0000_5002, 32'h0, 5'd12);
    @(posedge clk); #1;
    check("reset_test_in_wait", W'(lsu_busy_o), W'(1));
    rst_n = 1'b0;
    #2;
    check("midreset_mem_port", W'({data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o}), '0);
    check("midreset_wb_port", W'({wb_valid_o, wb_rd_o, wb_data_o, misaligned_o, bus_err_o, lsu_busy_o}), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    data_rvalid_i = 1'b1; data_rdata_i = 32'hCAFE_8000;
    @(posedge clk); #1;
    data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
    repeat (3) begin @(posedge clk); #1; end
    check("postreset_wb_port", W'({wb_valid_o, wb_rd_o, wb_data_o, lsu_busy_o}), '0);

    check("scoreboard_drained", W'(exp_q.size()), W'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Memory-stage load/store unit of the RV32I pipeline. It sits between the EX/MEM pipeline register and the data-memory port.
- Takes the load/store function code, effective address and store data from EX, and runs a req/gnt/rvalid handshake to data memory.
- Produces byte enables and lane-replicated store data, and sign- or zero-extends load data.
- Drives a stall signal upstream and a registered writeback result toward the WB stage.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles waiting for gnt or rvalid before the access is aborted.
- CNT_W, 7: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk, in, 1: core clock; all state changes on the rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- ex_valid_i, in, 1: EX/MEM register holds a valid instruction.
- ls_func_i, in, 4: load_store_func_code. NOP=0, LW=1, LH=2, LB=3, LHU=4, LBU=5, SW=6, SH=7, SB=8; codes 9-15 are treated as NOP.
- addr_i, in, 32: effective byte address (ALU result).
- wdata_i, in, 32: store source data, already forwarded.
- rd_i, in, 5: load destination register.
- data_req_o, out, 1: memory request.
- data_gnt_i, in, 1: request accepted by memory.
- data_we_o, out, 1: 1 = store.
- data_be_o, out, 4: byte enables.
- data_addr_o, out, 32: word address, {addr[31:2], 2'b00}.
- data_wdata_o, out, 32: lane-replicated store data.
- data_rvalid_i, in, 1: read data valid.
- data_rdata_i, in, 32: read word.
- lsu_busy_o, out, 1: stall for IF/ID/EX/MEM; high whenever state != IDLE.
- wb_valid_o, out, 1: one-cycle pulse, load result valid.
- wb_rd_o, out, 5: destination of the load.
- wb_data_o, out, 32: extended load data.
- misaligned_o, out, 1: one-cycle pulse, misaligned access rejected.
- bus_err_o, out, 1: one-cycle pulse, timeout abort.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; counter=0.
  - All outputs 0, including data_be_o, data_addr_o, data_wdata_o, wb_rd_o and wb_data_o.
  - Reset mid-access abandons the access. An rvalid arriving after reset is ignored.
- States: IDLE, REQ, WAIT_RVALID.
- IDLE:
  - Accept when ex_valid_i=1 and ls_func_i is not NOP.
  - Misaligned cases:
    - LW/SW with addr_i[1:0] != 0.
    - LH/LHU/SH with addr_i[0] = 1.
  - On misalign: register misaligned_o=1 for one cycle, issue no request, stay in IDLE.
  - On an aligned op: register addr, be, wdata, we, func and rd; go to REQ; counter=0.
- Byte enables and store data:
  - Word: be=4'b1111, wdata=wdata_i.
  - Half: be=4'b0011<<addr[1:0], wdata={2{wdata_i[15:0]}}.
  - Byte: be=4'b0001<<addr[1:0], wdata={4{wdata_i[7:0]}}.
  - Loads use the same be pattern.
- REQ:
  - data_req_o=1, with address/be/we/wdata held stable until the gnt cycle inclusive.
  - On data_gnt_i=1: a store returns to IDLE (no writeback); a load goes to WAIT_RVALID. Counter clears either way.
  - No gnt: counter++. When counter reaches TIMEOUT_CYCLES-1 without gnt: pulse bus_err_o, drop req, go to IDLE.
- WAIT_RVALID:
  - data_req_o=0.
  - On data_rvalid_i=1:
    - Shift: sh = data_rdata_i >> (8*addr[1:0]).
    - LB: sign-extend sh[7:0]. LBU: zero-extend sh[7:0].
    - LH: sign-extend sh[15:0]. LHU: zero-extend sh[15:0].
    - LW: sh unchanged.
    - Register wb_data_o, wb_rd_o and wb_valid_o=1 for exactly one cycle, then go to IDLE.
  - Timeout in this state follows the same rule as REQ.
  - An rvalid in the same cycle as gnt is ignored; rvalid is valid only in WAIT_RVALID.
- Writeback outputs:
  - wb_valid_o, misaligned_o and bus_err_o are registered and deasserted on the following cycle.
  - wb_data_o and wb_rd_o hold their last value.
- Latency:
  - Store: 1 cycle (IDLE->REQ) plus gnt wait.
  - Load: result appears on the cycle after the rvalid edge. Minimum 3 cycles, with gnt at the first REQ cycle and rvalid on the next.
- Stall and back-to-back ops:
  - lsu_busy_o holds the upstream op stable.
  - A new op is sampled only in IDLE, so back-to-back accesses have one IDLE cycle between them.
- rd=0 loads still perform the access and pulse wb_valid_o; the regfile discards the write.

Test Plan:
- SW, addr=0x1004, wdata=0xDEADBEEF, gnt on the first REQ cycle -> data_addr_o=0x1004, be=4'b1111, we=1, req high 1 cycle, lsu_busy_o high 1 cycle, no wb_valid_o.
- SB, addr=0x2003, wdata=0x000000A5 -> be=4'b1000, data_wdata_o=0xA5A5A5A5, data_addr_o=0x2000.
- LB, addr=0x3002, rdata=0x0080FF11, rvalid 2 cycles after gnt -> wb_data_o=0xFFFFFF80, one-cycle wb_valid_o. LBU at the same address -> 0x00000080.
- LH, addr=0x4001 -> misaligned_o pulses once, data_req_o stays 0, state stays IDLE. LW at 0x4002 gives the same result.
- LW with gnt withheld TIMEOUT_CYCLES=64 cycles -> bus_err_o pulses, req drops, lsu_busy_o falls, no writeback.
- LHU, addr=0x5002, rst_n asserted in WAIT_RVALID, then rvalid=1 after release -> all outputs 0, rvalid ignored, no wb_valid_o.
